mem_arbiter: RTL and testbench

- Shares the core's single memory bus port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Accepts one transaction at a time from the selected requester, sequences it on the bus, and routes the response back to that requester.
- Bus errors and timeouts are returned as an error flag; the pipeline turns these into an access-fault ecause.
- Sits between the pipeline and the external bus.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: fetch port, data port and the shared memory bus.
// The arbiter connects through 'master'; the pipeline/bus environment uses 'slave'.
interface mem_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_address;
    logic        fetch_abort;
    logic        fetch_ready;
    logic        fetch_resp_valid;
    logic [31:0] fetch_data;
    logic        fetch_error;

    logic        data_req;
    logic [31:0] data_address;
    logic        data_write;
    logic [31:0] data_write_data;
    logic [3:0]  data_strobe;
    logic        data_ready;
    logic        data_resp_valid;
    logic [31:0] data_read_data;
    logic        data_error;

    logic        mem_valid;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_strobe;
    logic        mem_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_read_data;
    logic        mem_error;

    modport master (
        input  fetch_req, fetch_address, fetch_abort,
        output fetch_ready, fetch_resp_valid, fetch_data, fetch_error,
        input  data_req, data_address, data_write, data_write_data, data_strobe,
        output data_ready, data_resp_valid, data_read_data, data_error,
        output mem_valid, mem_address, mem_write, mem_write_data, mem_strobe,
        input  mem_ready, mem_resp_valid, mem_read_data, mem_error
    );

    modport slave (
        output fetch_req, fetch_address, fetch_abort,
        input  fetch_ready, fetch_resp_valid, fetch_data, fetch_error,
        output data_req, data_address, data_write, data_write_data, data_strobe,
        input  data_ready, data_resp_valid, data_read_data, data_error,
        input  mem_valid, mem_address, mem_write, mem_write_data, mem_strobe,
        output mem_ready, mem_resp_valid, mem_read_data, mem_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and the data stage, one transaction at a time.
// Optional macro ROUND_ROBIN_EN: alternate grants on ties instead of fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        aborted_q, aborted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic [3:0]  mem_strobe_q, mem_strobe_d;

    logic        fetch_ready_q, fetch_ready_d;
    logic        fetch_resp_valid_q, fetch_resp_valid_d;
    logic [31:0] fetch_data_q, fetch_data_d;
    logic        fetch_error_q, fetch_error_d;
    logic        data_ready_q, data_ready_d;
    logic        data_resp_valid_q, data_resp_valid_d;
    logic [31:0] data_read_data_q, data_read_data_d;
    logic        data_error_q, data_error_d;

    logic        grant_data, grant_fetch;
    logic        timeout_hit;
    logic        done, done_error;
    logic [31:0] done_rdata;

`ifdef ROUND_ROBIN_EN
    owner_t      last_q, last_d;
`endif

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        grant_data  = bus.data_req;
        grant_fetch = bus.fetch_req && !bus.data_req;
`ifdef ROUND_ROBIN_EN
        if (bus.data_req && bus.fetch_req) begin
            grant_data  = (last_q == OWN_FETCH);
            grant_fetch = (last_q == OWN_DATA);
        end
`endif
    end

    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        aborted_d          = aborted_q;
        cnt_d              = cnt_q;
        mem_valid_d        = mem_valid_q;
        mem_address_d      = mem_address_q;
        mem_write_d        = mem_write_q;
        mem_write_data_d   = mem_write_data_q;
        mem_strobe_d       = mem_strobe_q;
        fetch_ready_d      = 1'b0;
        fetch_resp_valid_d = 1'b0;
        fetch_data_d       = fetch_data_q;
        fetch_error_d      = fetch_error_q;
        data_ready_d       = 1'b0;
        data_resp_valid_d  = 1'b0;
        data_read_data_d   = data_read_data_q;
        data_error_d       = data_error_q;
        done               = 1'b0;
        done_error         = 1'b0;
        done_rdata         = 32'd0;
`ifdef ROUND_ROBIN_EN
        last_d             = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    data_ready_d     = 1'b1;
                    owner_d          = OWN_DATA;
                    mem_address_d    = bus.data_address;
                    mem_write_d      = bus.data_write;
                    mem_write_data_d = bus.data_write_data;
                    mem_strobe_d     = bus.data_strobe;
                    cnt_d            = '0;
                    state_d          = REQ;
`ifdef ROUND_ROBIN_EN
                    last_d           = OWN_DATA;
`endif
                end else if (grant_fetch) begin
                    fetch_ready_d    = 1'b1;
                    owner_d          = OWN_FETCH;
                    mem_address_d    = bus.fetch_address;
                    mem_write_d      = 1'b0;
                    mem_strobe_d     = 4'b1111;
                    cnt_d            = '0;
                    state_d          = REQ;
`ifdef ROUND_ROBIN_EN
                    last_d           = OWN_FETCH;
`endif
                end
            end
            REQ: begin
                // mem_valid is still low in the cycle right after the grant; raise it now
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                end else if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (bus.mem_resp_valid) begin
                        done       = 1'b1;
                        done_error = bus.mem_error;
                        done_rdata = bus.mem_read_data;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    done       = 1'b1;
                    done_error = bus.mem_error;
                    done_rdata = bus.mem_read_data;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == REQ || state_q == WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.fetch_abort && owner_q == OWN_FETCH) aborted_d = 1'b1;
            // A real response in the timeout cycle takes precedence over the forced error
            if (!done && timeout_hit) begin
                done        = 1'b1;
                done_error  = 1'b1;
                done_rdata  = 32'd0;
                mem_valid_d = 1'b0;
            end
        end

        if (done) begin
            state_d   = IDLE;
            aborted_d = 1'b0;
            if (owner_q == OWN_DATA) begin
                data_resp_valid_d = 1'b1;
                data_read_data_d  = done_rdata;
                data_error_d      = done_error;
            end else if (!(aborted_q || bus.fetch_abort)) begin
                fetch_resp_valid_d = 1'b1;
                fetch_data_d       = done_rdata;
                fetch_error_d      = done_error;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            owner_q            <= OWN_FETCH;
            aborted_q          <= 1'b0;
            cnt_q              <= '0;
            mem_valid_q        <= 1'b0;
            mem_address_q      <= 32'd0;
            mem_write_q        <= 1'b0;
            mem_write_data_q   <= 32'd0;
            mem_strobe_q       <= 4'd0;
            fetch_ready_q      <= 1'b0;
            fetch_resp_valid_q <= 1'b0;
            fetch_data_q       <= 32'd0;
            fetch_error_q      <= 1'b0;
            data_ready_q       <= 1'b0;
            data_resp_valid_q  <= 1'b0;
            data_read_data_q   <= 32'd0;
            data_error_q       <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q             <= OWN_FETCH;
`endif
        end else begin
            state_q            <= state_d;
            owner_q            <= owner_d;
            aborted_q          <= aborted_d;
            cnt_q              <= cnt_d;
            mem_valid_q        <= mem_valid_d;
            mem_address_q      <= mem_address_d;
            mem_write_q        <= mem_write_d;
            mem_write_data_q   <= mem_write_data_d;
            mem_strobe_q       <= mem_strobe_d;
            fetch_ready_q      <= fetch_ready_d;
            fetch_resp_valid_q <= fetch_resp_valid_d;
            fetch_data_q       <= fetch_data_d;
            fetch_error_q      <= fetch_error_d;
            data_ready_q       <= data_ready_d;
            data_resp_valid_q  <= data_resp_valid_d;
            data_read_data_q   <= data_read_data_d;
            data_error_q       <= data_error_d;
`ifdef ROUND_ROBIN_EN
            last_q             <= last_d;
`endif
        end
    end

    assign bus.fetch_ready      = fetch_ready_q;
    assign bus.fetch_resp_valid = fetch_resp_valid_q;
    assign bus.fetch_data       = fetch_data_q;
    assign bus.fetch_error      = fetch_error_q;
    assign bus.data_ready       = data_ready_q;
    assign bus.data_resp_valid  = data_resp_valid_q;
    assign bus.data_read_data   = data_read_data_q;
    assign bus.data_error       = data_error_q;
    assign bus.mem_valid        = mem_valid_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write        = mem_write_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_strobe       = mem_strobe_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter; expected grants, bus fields and
// responses come from a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter_if bus2 ();

    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus.master));
    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (.clk(clk), .reset(reset), .bus(bus2.master));

    int checks = 0;
    int failures = 0;
    bit last_was_data = 1'b0;
    bit rr_mode = 1'b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One complete transaction on the main arbiter. Bus timing: mem_ready is withheld
    // rdy_dly cycles, the response comes rsp_dly cycles after mem_ready (0 = same cycle).
    task automatic txn(input bit fq, input bit dq, input logic [31:0] fa, input logic [31:0] da,
                       input bit dw, input logic [31:0] dwd, input logic [3:0] ds,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] rd,
                       input bit er, input bit ab, output bit wd);
        logic [31:0] exp_addr;
        bit suppress;
        wd = dq;
        if (rr_mode && fq && dq) wd = !last_was_data;
        last_was_data = wd;
        exp_addr = wd ? da : fa;
        suppress = ab && !wd && (rsp_dly > 0);

        bus.fetch_req = fq;  bus.fetch_address = fa;
        bus.data_req = dq;   bus.data_address = da;  bus.data_write = dw;
        bus.data_write_data = dwd;  bus.data_strobe = ds;
        tick();
        check1("data_ready", bus.data_ready, wd);
        check1("fetch_ready", bus.fetch_ready, !wd);
        check1("mem_valid_at_grant", bus.mem_valid, 1'b0);
        if (wd) bus.data_req = 1'b0; else bus.fetch_req = 1'b0;

        tick();
        check1("mem_valid", bus.mem_valid, 1'b1);
        check32("mem_address", bus.mem_address, exp_addr);
        check1("mem_write", bus.mem_write, wd ? dw : 1'b0);
        check32("mem_strobe", 32'(bus.mem_strobe), wd ? 32'(ds) : 32'hf);
        if (wd && dw) check32("mem_write_data", bus.mem_write_data, dwd);
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            check1("hold_mem_valid", bus.mem_valid, 1'b1);
            check32("hold_mem_address", bus.mem_address, exp_addr);
            check1("no_repeat_ready", bus.fetch_ready | bus.data_ready, 1'b0);
        end

        bus.mem_ready = 1'b1;
        if (rsp_dly == 0) begin
            bus.mem_resp_valid = 1'b1; bus.mem_read_data = rd; bus.mem_error = er;
        end
        tick();
        bus.mem_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        check1("mem_valid_drop", bus.mem_valid, 1'b0);
        if (rsp_dly > 0) begin
            if (ab) bus.fetch_abort = 1'b1;
            for (int j = 1; j < rsp_dly; j++) begin
                check1("early_resp", bus.fetch_resp_valid | bus.data_resp_valid, 1'b0);
                tick();
                bus.fetch_abort = 1'b0;
            end
            bus.mem_resp_valid = 1'b1; bus.mem_read_data = rd; bus.mem_error = er;
            tick();
            bus.mem_resp_valid = 1'b0; bus.fetch_abort = 1'b0;
        end

        check1("fetch_resp_valid", bus.fetch_resp_valid, !wd && !suppress);
        check1("data_resp_valid", bus.data_resp_valid, wd);
        check1("ready_with_resp", bus.fetch_ready | bus.data_ready, 1'b0);
        if (wd) begin
            check1("data_error", bus.data_error, er);
            if (!dw) check32("data_read_data", bus.data_read_data, rd);
        end else if (!suppress) begin
            check1("fetch_error", bus.fetch_error, er);
            check32("fetch_data", bus.fetch_data, rd);
        end
    endtask

    initial begin
        bit wd;
        bit pf, pd;
        logic [31:0] hfa, hda, hdwd;
        bit hdw;
        logic [3:0] hds;
`ifdef ROUND_ROBIN_EN
        rr_mode = 1'b1;
`endif
        bus.fetch_req = 0; bus.fetch_address = 0; bus.fetch_abort = 0;
        bus.data_req = 0; bus.data_address = 0; bus.data_write = 0;
        bus.data_write_data = 0; bus.data_strobe = 0;
        bus.mem_ready = 0; bus.mem_resp_valid = 0; bus.mem_read_data = 0; bus.mem_error = 0;
        bus2.fetch_req = 0; bus2.fetch_address = 0; bus2.fetch_abort = 0;
        bus2.data_req = 0; bus2.data_address = 0; bus2.data_write = 0;
        bus2.data_write_data = 0; bus2.data_strobe = 0;
        bus2.mem_ready = 0; bus2.mem_resp_valid = 0; bus2.mem_read_data = 0; bus2.mem_error = 0;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check1("rst_mem_valid", bus.mem_valid, 1'b0);
        check1("rst_fetch_ready", bus.fetch_ready, 1'b0);
        check1("rst_data_ready", bus.data_ready, 1'b0);
        check1("rst_fetch_resp", bus.fetch_resp_valid, 1'b0);
        check1("rst_data_resp", bus.data_resp_valid, 1'b0);
        check1("rst_errors", bus.fetch_error | bus.data_error, 1'b0);
        check32("rst_mem_address", bus.mem_address, 32'd0);
        check32("rst_mem_write_data", bus.mem_write_data, 32'd0);
        check32("rst_mem_strobe", 32'(bus.mem_strobe), 32'd0);
        check1("rst_mem_write", bus.mem_write, 1'b0);
        check32("rst_fetch_data", bus.fetch_data, 32'd0);
        check32("rst_data_read_data", bus.data_read_data, 32'd0);
        check1("rst_to_mem_valid", bus2.mem_valid, 1'b0);

        // basic fetch read with minimum latency
        txn(1, 0, 32'h0000_0100, 0, 0, 0, 0, 0, 1, 32'h0000_0013, 0, 0, wd);

        // stray response while idle
        bus.mem_resp_valid = 1'b1; bus.mem_read_data = 32'hBAD0_BAD0;
        tick();
        bus.mem_resp_valid = 1'b0;
        check1("stray_resp", bus.fetch_resp_valid | bus.data_resp_valid, 1'b0);
        check1("stray_ready", bus.fetch_ready | bus.data_ready, 1'b0);

        // tie: store wins first, then fetch (RR: against a fresh data request)
        txn(1, 1, 32'h0000_3000, 32'h0000_2000, 1, 32'hDEAD_BEEF, 4'b0011, 0, 1, 0, 0, 0, wd);
        txn(1, rr_mode, 32'h0000_3000, 32'h0000_2004, 0, 0, 4'b1111, 0, 1, 32'h1111_2222, 0, 0, wd);
        check1("second_grant_fetch", wd, 1'b0);
        if (rr_mode) txn(0, 1, 0, 32'h0000_2004, 0, 0, 4'b1111, 1, 0, 32'h3333_4444, 0, 0, wd);

        // mem_ready withheld for 3 cycles
        txn(0, 1, 0, 32'h0000_0040, 0, 0, 4'b1111, 3, 1, 32'h5555_6666, 0, 0, wd);

        // aborted fetch, then a data request accepted right after
        txn(1, 0, 32'h0000_0200, 0, 0, 0, 0, 0, 2, 32'h7777_8888, 0, 1, wd);
        txn(0, 1, 0, 32'h0000_0044, 0, 0, 4'b1111, 0, 1, 32'h9999_AAAA, 0, 0, wd);

        // bus error on a load
        txn(0, 1, 0, 32'h0000_0048, 0, 0, 4'b1111, 0, 2, 32'h1234_5678, 1, 0, wd);

        // timeout unit: response arriving in the timeout cycle wins
        bus2.data_req = 1'b1; bus2.data_address = 32'h0000_0800;
        tick();
        check1("to_ready", bus2.data_ready, 1'b1);
        bus2.data_req = 1'b0;
        tick();
        check1("to_mem_valid", bus2.mem_valid, 1'b1);
        bus2.mem_ready = 1'b1;
        tick();
        bus2.mem_ready = 1'b0;
        tick();
        bus2.mem_resp_valid = 1'b1; bus2.mem_read_data = 32'hA5A5_5A5A;
        tick();
        bus2.mem_resp_valid = 1'b0;
        check1("to_edge_resp", bus2.data_resp_valid, 1'b1);
        check1("to_edge_error", bus2.data_error, 1'b0);
        check32("to_edge_data", bus2.data_read_data, 32'hA5A5_5A5A);

        // timeout unit: bus never answers
        bus2.data_req = 1'b1; bus2.data_address = 32'h0000_0804;
        tick();
        check1("to2_ready", bus2.data_ready, 1'b1);
        bus2.data_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check1("to2_no_resp", bus2.data_resp_valid, 1'b0);
        end
        tick();
        check1("to2_resp", bus2.data_resp_valid, 1'b1);
        check1("to2_error", bus2.data_error, 1'b1);
        check32("to2_data", bus2.data_read_data, 32'd0);
        check1("to2_mem_valid", bus2.mem_valid, 1'b0);
        bus2.mem_resp_valid = 1'b1; bus2.mem_read_data = 32'hFFFF_0000;
        tick();
        bus2.mem_resp_valid = 1'b0;
        check1("to2_stray", bus2.data_resp_valid, 1'b0);
        check32("to2_stray_data", bus2.data_read_data, 32'd0);

        // reset in the middle of a fetch
        bus.fetch_req = 1'b1; bus.fetch_address = 32'h0000_0300;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_was_data = 1'b0;
        check1("midrst_mem_valid", bus.mem_valid, 1'b0);
        bus.mem_resp_valid = 1'b1; bus.mem_read_data = 32'hCAFE_F00D;
        tick();
        bus.mem_resp_valid = 1'b0;
        check1("midrst_no_resp", bus.fetch_resp_valid | bus.data_resp_valid, 1'b0);

        // randomized traffic with held losing requests
        pf = 0; pd = 0; hfa = 0; hda = 0; hdwd = 0; hdw = 0; hds = 0;
        for (int n = 0; n < 60; n++) begin
            bit fq, dq, ab, er;
            int rdl, rsl;
            fq = pf || ($urandom_range(0, 1) == 1);
            dq = pd || ($urandom_range(0, 1) == 1);
            if (!fq && !dq) fq = 1'b1;
            if (fq && !pf) hfa = $urandom;
            if (dq && !pd) begin
                hda = $urandom; hdw = 1'($urandom_range(0, 1));
                hdwd = $urandom; hds = 4'($urandom_range(0, 15));
            end
            rdl = $urandom_range(0, 3);
            rsl = $urandom_range(0, 3);
            er = ($urandom_range(0, 7) == 0);
            ab = (rsl >= 2) && ($urandom_range(0, 4) == 0);
            txn(fq, dq, hfa, hda, hdw, hdwd, hds, rdl, rsl, $urandom, er, ab, wd);
            pf = fq && wd;
            pd = dq && !wd;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
